// File: rtl/hs32_mem_arbiter.sv
// hs32_mem_arbiter: two-requester memory arbiter that serves one fetch port and
// one execute port against a single memory bus. Only one transaction is in
// flight at a time. Execute wins a collision until fetch has waited
// STARVE_LIMIT grants. Bus outputs are registered and held until m_ack.
module hs32_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3   // legal 1..7
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic [31:0] f_addr,
  input  logic        f_reqm,
  output logic [31:0] f_dtr,
  output logic        f_rdym,
  input  logic        flush,
  // execute port
  input  logic [31:0] e_addr,
  input  logic [31:0] e_dtw,
  input  logic        e_rw,
  input  logic        e_reqm,
  output logic [31:0] e_dtr,
  output logic        e_rdym,
  // memory bus
  output logic [31:0] m_addr,
  output logic [31:0] m_dtw,
  output logic        m_rw,
  output logic        m_stb,
  input  logic        m_ack,
  input  logic [31:0] m_dtr
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_dtw_q, m_dtw_d;
  logic        m_rw_q, m_rw_d;
  logic        m_stb_q, m_stb_d;
  logic        fetch_ok, gnt_e, gnt_f;

  // A flush blocks new fetch grants only; execute keeps priority until fetch
  // has been passed over STARVE_LIMIT times in a row.
  assign fetch_ok = f_reqm && !flush;
  assign gnt_e    = e_reqm && !(fetch_ok && (starve_q == LIMIT));
  assign gnt_f    = !gnt_e && fetch_ok;

  // Read data is broadcast; the rdym pulse alone qualifies it.
  assign f_dtr  = m_dtr;
  assign e_dtr  = m_dtr;
  assign m_addr = m_addr_q;
  assign m_dtw  = m_dtw_q;
  assign m_rw   = m_rw_q;
  assign m_stb  = m_stb_q;

  // Next-state, bus latch and completion pulses.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    m_addr_d = m_addr_q;
    m_dtw_d  = m_dtw_q;
    m_rw_d   = m_rw_q;
    m_stb_d  = m_stb_q;
    f_rdym   = 1'b0;
    e_rdym   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_e) begin
          state_d  = EXEC;
          m_addr_d = e_addr;
          m_dtw_d  = e_dtw;
          m_rw_d   = e_rw;
          m_stb_d  = 1'b1;
          // Count only grants that actually made fetch wait.
          if (f_reqm && (starve_q != LIMIT)) starve_d = starve_q + 3'd1;
        end else if (gnt_f) begin
          state_d  = FETCH;
          m_addr_d = f_addr;
          m_rw_d   = 1'b0;
          m_stb_d  = 1'b1;
          starve_d = 3'd0;
        end
      end
      FETCH: begin
        if (m_ack) begin
          // A flushed fetch still completes on the bus but is not reported.
          f_rdym  = reset && !flush;
          state_d = IDLE;
          m_stb_d = 1'b0;
        end
      end
      EXEC: begin
        if (m_ack) begin
          e_rdym  = reset;
          state_d = IDLE;
          m_stb_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        m_stb_d = 1'b0;
      end
    endcase
  end

  // State and bus registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      starve_q <= 3'd0;
      m_addr_q <= 32'd0;
      m_dtw_q  <= 32'd0;
      m_rw_q   <= 1'b0;
      m_stb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      m_addr_q <= m_addr_d;
      m_dtw_q  <= m_dtw_d;
      m_rw_q   <= m_rw_d;
      m_stb_q  <= m_stb_d;
    end
  end

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Directed bench for hs32_mem_arbiter: a per-cycle vector table plus a
// starvation sequence and a bus-stability monitor.
module tb_hs32_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f_addr, f_dtr, e_addr, e_dtw, e_dtr, m_addr, m_dtw, m_dtr;
  logic        f_reqm, f_rdym, flush, e_rw, e_reqm, e_rdym, m_rw, m_stb, m_ack;

  int checks = 0;
  int errors = 0;

  hs32_mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .f_addr(f_addr), .f_reqm(f_reqm), .f_dtr(f_dtr), .f_rdym(f_rdym), .flush(flush),
    .e_addr(e_addr), .e_dtw(e_dtw), .e_rw(e_rw), .e_reqm(e_reqm),
    .e_dtr(e_dtr), .e_rdym(e_rdym),
    .m_addr(m_addr), .m_dtw(m_dtw), .m_rw(m_rw), .m_stb(m_stb),
    .m_ack(m_ack), .m_dtr(m_dtr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
    end
  endtask

  // Bus must hold while strobed and unacknowledged; completions exclusive.
  logic        p_rst, p_stb, p_ack, p_rw;
  logic [31:0] p_addr, p_dtw;
  always @(posedge clk) begin
    p_rst = reset; p_stb = m_stb; p_ack = m_ack;
    p_addr = m_addr; p_dtw = m_dtw; p_rw = m_rw;
    checks++;
    if (f_rdym === 1'b1 && e_rdym === 1'b1) begin
      errors++;
      $display("FAIL rdym_exclusive got=both expected=at_most_one");
    end
    #1;
    if (p_rst === 1'b1 && p_stb === 1'b1 && p_ack === 1'b0) begin
      checks++;
      if (m_stb !== 1'b1 || m_addr !== p_addr || m_dtw !== p_dtw || m_rw !== p_rw) begin
        errors++;
        $display("FAIL bus_stable got=%b/%h/%h/%b expected=1/%h/%h/%b",
                 m_stb, m_addr, m_dtw, m_rw, p_addr, p_dtw, p_rw);
      end
    end
  end

  typedef struct {
    logic        rst, fr;
    logic [31:0] fa;
    logic        er, erw;
    logic [31:0] ea, ed;
    logic        fl, ack;
    logic [31:0] dtr;
    logic        stb;
    logic [31:0] maddr, mdtw;
    logic        mrw, frdy, erdy;
  } vec_t;

  function automatic vec_t mk(logic rst, logic fr, logic [31:0] fa, logic er, logic erw,
                              logic [31:0] ea, logic [31:0] ed, logic fl, logic ack,
                              logic [31:0] dtr, logic stb, logic [31:0] maddr,
                              logic [31:0] mdtw, logic mrw, logic frdy, logic erdy);
    vec_t v;
    v.rst = rst; v.fr = fr; v.fa = fa; v.er = er; v.erw = erw; v.ea = ea; v.ed = ed;
    v.fl = fl; v.ack = ack; v.dtr = dtr; v.stb = stb; v.maddr = maddr; v.mdtw = mdtw;
    v.mrw = mrw; v.frdy = frdy; v.erdy = erdy;
    return v;
  endfunction

  vec_t tv[23];

  initial begin
    // Inputs of each row apply for one cycle; expected outputs are observed
    // within that same cycle (registered state from the previous edge).
    //         rst fr fa      er erw ea     ed     fl ack dtr            stb maddr  mdtw   rw fr er
    tv[0]  = mk(0, 1, 32'h100, 0, 0, 32'h0,  32'h0,  0, 0, 32'h0,        0, 32'h0,  32'h0,  0, 0, 0);
    tv[1]  = mk(1, 1, 32'h100, 0, 0, 32'h0,  32'h0,  0, 0, 32'h0,        0, 32'h0,  32'h0,  0, 0, 0);
    tv[2]  = mk(1, 1, 32'h100, 0, 0, 32'h0,  32'h0,  0, 0, 32'h0,        1, 32'h100,32'h0,  0, 0, 0);
    tv[3]  = mk(1, 1, 32'h100, 0, 0, 32'h0,  32'h0,  0, 0, 32'h0,        1, 32'h100,32'h0,  0, 0, 0);
    tv[4]  = mk(1, 1, 32'h100, 0, 0, 32'h0,  32'h0,  0, 1, 32'hDEADBEEF, 1, 32'h100,32'h0,  0, 1, 0);
    tv[5]  = mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  0, 0, 32'h0,        0, 32'h100,32'h0,  0, 0, 0);
    tv[6]  = mk(1, 0, 32'h0,   1, 0, 32'h8,  32'hAA, 0, 0, 32'h0,        0, 32'h100,32'h0,  0, 0, 0);
    tv[7]  = mk(1, 0, 32'h0,   1, 0, 32'h8,  32'hAA, 0, 1, 32'h1234,     1, 32'h8,  32'hAA, 0, 0, 1);
    tv[8]  = mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  0, 0, 32'h0,        0, 32'h8,  32'hAA, 0, 0, 0);
    tv[9]  = mk(1, 1, 32'h300, 0, 0, 32'h0,  32'h0,  0, 0, 32'h0,        0, 32'h8,  32'hAA, 0, 0, 0);
    tv[10] = mk(1, 1, 32'h300, 0, 0, 32'h0,  32'h0,  1, 0, 32'h0,        1, 32'h300,32'hAA, 0, 0, 0);
    tv[11] = mk(1, 1, 32'h300, 0, 0, 32'h0,  32'h0,  1, 1, 32'h5,        1, 32'h300,32'hAA, 0, 0, 0);
    tv[12] = mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  0, 0, 32'h0,        0, 32'h300,32'hAA, 0, 0, 0);
    tv[13] = mk(1, 1, 32'h400, 0, 0, 32'h0,  32'h0,  1, 0, 32'h0,        0, 32'h300,32'hAA, 0, 0, 0);
    tv[14] = mk(1, 1, 32'h400, 0, 0, 32'h0,  32'h0,  0, 0, 32'h0,        0, 32'h300,32'hAA, 0, 0, 0);
    tv[15] = mk(1, 1, 32'h400, 0, 0, 32'h0,  32'h0,  0, 1, 32'h77,       1, 32'h400,32'hAA, 0, 1, 0);
    tv[16] = mk(1, 0, 32'h0,   1, 1, 32'h10, 32'h99, 1, 0, 32'h0,        0, 32'h400,32'hAA, 0, 0, 0);
    tv[17] = mk(1, 0, 32'h0,   1, 1, 32'h10, 32'h99, 0, 1, 32'h0,        1, 32'h10, 32'h99, 1, 0, 1);
    tv[18] = mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  0, 0, 32'h0,        0, 32'h10, 32'h99, 1, 0, 0);
    tv[19] = mk(1, 0, 32'h0,   1, 0, 32'h20, 32'h11, 0, 0, 32'h0,        0, 32'h10, 32'h99, 1, 0, 0);
    tv[20] = mk(0, 0, 32'h0,   1, 0, 32'h20, 32'h11, 0, 1, 32'hCAFE,     1, 32'h20, 32'h11, 0, 0, 0);
    tv[21] = mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  0, 0, 32'h0,        0, 32'h0,  32'h0,  0, 0, 0);
    tv[22] = mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,  0, 1, 32'h9,        0, 32'h0,  32'h0,  0, 0, 0);

    reset = 1'b0; f_reqm = 1'b0; f_addr = '0; flush = 1'b0; e_reqm = 1'b0; e_rw = 1'b0;
    e_addr = '0; e_dtw = '0; m_ack = 1'b0; m_dtr = '0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 23; i++) begin
      reset = tv[i].rst; f_reqm = tv[i].fr; f_addr = tv[i].fa; e_reqm = tv[i].er;
      e_rw = tv[i].erw; e_addr = tv[i].ea; e_dtw = tv[i].ed; flush = tv[i].fl;
      m_ack = tv[i].ack; m_dtr = tv[i].dtr;
      #1;
      chk("m_stb",  i, {31'd0, m_stb},  {31'd0, tv[i].stb});
      chk("m_addr", i, m_addr, tv[i].maddr);
      chk("m_dtw",  i, m_dtw,  tv[i].mdtw);
      chk("m_rw",   i, {31'd0, m_rw},   {31'd0, tv[i].mrw});
      chk("f_rdym", i, {31'd0, f_rdym}, {31'd0, tv[i].frdy});
      chk("e_rdym", i, {31'd0, e_rdym}, {31'd0, tv[i].erdy});
      chk("f_dtr",  i, f_dtr, tv[i].dtr);
      chk("e_dtr",  i, e_dtr, tv[i].dtr);
      @(negedge clk);
    end

    // Both requesters held, one-cycle acks: expect E E E F repeating.
    begin
      int g = 0;
      reset = 1'b1; flush = 1'b0; m_ack = 1'b0; m_dtr = 32'h0;
      f_reqm = 1'b1; f_addr = 32'h100;
      e_reqm = 1'b1; e_rw = 1'b1; e_addr = 32'h200; e_dtw = 32'h55;
      for (int c = 0; c < 60 && g < 8; c++) begin
        @(negedge clk);
        m_ack = 1'b0;
        #1;
        if (m_stb === 1'b1) begin
          m_ack = 1'b1;
          #1;
          if ((g % 4) == 3) begin
            chk("starve_addr_f", 100 + g, m_addr, 32'h100);
            chk("starve_rw_f",   100 + g, {31'd0, m_rw},   32'd0);
            chk("starve_dtw_f",  100 + g, m_dtw, 32'h55);
            chk("starve_frdy",   100 + g, {31'd0, f_rdym}, 32'd1);
            chk("starve_erdy_f", 100 + g, {31'd0, e_rdym}, 32'd0);
          end else begin
            chk("starve_addr_e", 100 + g, m_addr, 32'h200);
            chk("starve_rw_e",   100 + g, {31'd0, m_rw},   32'd1);
            chk("starve_dtw_e",  100 + g, m_dtw, 32'h55);
            chk("starve_erdy",   100 + g, {31'd0, e_rdym}, 32'd1);
            chk("starve_frdy_e", 100 + g, {31'd0, f_rdym}, 32'd0);
          end
          g++;
        end
      end
      chk("starve_grants", 199, g, 8);
      @(negedge clk);
      m_ack = 1'b0; f_reqm = 1'b0; e_reqm = 1'b0;
      repeat (2) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
